// File: rtl/adf4158_pkg.sv
// rtl/adf4158_pkg.sv - ADF4158 register map constants and control-bit decode
package adf4158_pkg;

    localparam int WORD_W      = 32;
    localparam int NUM_REGS    = 10;
    localparam int RAMP_EN_BIT = 31;
    localparam int SEL_BIT     = 23;

    localparam logic [2:0] CTRL_R0 = 3'd0;
    localparam logic [2:0] CTRL_R1 = 3'd1;
    localparam logic [2:0] CTRL_R2 = 3'd2;
    localparam logic [2:0] CTRL_R3 = 3'd3;
    localparam logic [2:0] CTRL_R4 = 3'd4;
    localparam logic [2:0] CTRL_R5 = 3'd5;
    localparam logic [2:0] CTRL_R6 = 3'd6;
    localparam logic [2:0] CTRL_R7 = 3'd7;

    // R5 and R6 each own two consecutive bank slots, selected by bit 23
    localparam logic [3:0] IDX_R0 = 4'd0;
    localparam logic [3:0] IDX_R1 = 4'd1;
    localparam logic [3:0] IDX_R2 = 4'd2;
    localparam logic [3:0] IDX_R3 = 4'd3;
    localparam logic [3:0] IDX_R4 = 4'd4;
    localparam logic [3:0] IDX_R5 = 4'd5;
    localparam logic [3:0] IDX_R6 = 4'd7;
    localparam logic [3:0] IDX_R7 = 4'd9;

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    function automatic logic [3:0] decode_idx(input logic [WORD_W-1:0] w);
        logic [3:0] idx;
        case (w[2:0])
            CTRL_R0: idx = IDX_R0;
            CTRL_R1: idx = IDX_R1;
            CTRL_R2: idx = IDX_R2;
            CTRL_R3: idx = IDX_R3;
            CTRL_R4: idx = IDX_R4;
            CTRL_R5: idx = w[SEL_BIT] ? IDX_R5 + 4'd1 : IDX_R5;
            CTRL_R6: idx = w[SEL_BIT] ? IDX_R6 + 4'd1 : IDX_R6;
            default: idx = IDX_R7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/adf4158_spi_monitor_sync_edge_det.sv
// rtl/adf4158_spi_monitor_sync_edge_det.sv - input synchronizer with level and edge pulses
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain followed by one history flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/adf4158_spi_monitor.sv
// rtl/adf4158_spi_monitor.sv - ADF4158 CLK/DATA/LE receiver with shadow register bank
module adf4158_spi_monitor
    import adf4158_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              data_i,
    input  logic              le_i,
    output logic              wr_valid_o,
    output logic [3:0]        wr_idx_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              frame_err_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic              all_written_o,
    output logic              ramp_en_o,
    input  logic [3:0]        rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic data_s, data_rise_unused, data_fall_unused;
    logic le_s, le_rise, le_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_data (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(data_i),
        .level_o(data_s), .rise_o(data_rise_unused), .fall_o(data_fall_unused)
    );

    // LE idles high, so its synchronizer resets high to avoid a spurious edge
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_le (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(le_i),
        .level_o(le_s), .rise_o(le_rise), .fall_o(le_fall)
    );

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              commit, frame_err;
    logic [3:0]        commit_idx;

    logic              wr_valid_q, frame_err_q;
    logic [3:0]        wr_idx_q;
    logic [WORD_W-1:0] wr_data_q, rd_data_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [WORD_W-1:0] bank_q [NUM_REGS];
    logic [NUM_REGS-1:0] written_q;

    // Deserializer next state; an LE rise wins over a coincident sclk edge
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        commit    = 1'b0;
        frame_err = 1'b0;
        if (le_rise) begin
            if (bit_cnt_q == 6'd32) begin
                commit = 1'b1;
            end else begin
                frame_err = 1'b1;
            end
        end else begin
            if (le_fall) begin
                bit_cnt_d = 6'd0;
            end
            if (sclk_rise && !le_s) begin
                shift_d   = {shift_q[WORD_W-2:0], data_s};
                bit_cnt_d = (bit_cnt_d == 6'd33) ? bit_cnt_d : bit_cnt_d + 6'd1;
            end
        end
    end

    assign commit_idx = decode_idx(shift_q);

    // Shift register and saturating bit counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Commit into the bank, strobes and saturating frame-error count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            err_cnt_q   <= '0;
            bank_q      <= '{default: '0};
            written_q   <= '0;
        end else begin
            wr_valid_q  <= commit;
            frame_err_q <= frame_err;
            if (commit) begin
                wr_idx_q              <= commit_idx;
                wr_data_q             <= shift_q;
                bank_q[commit_idx]    <= shift_q;
                written_q[commit_idx] <= 1'b1;
            end
            if (frame_err && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    // Registered readback; indices past the bank read as zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= (rd_idx_i <= LAST_IDX) ? bank_q[rd_idx_i] : '0;
        end
    end

    assign wr_valid_o    = wr_valid_q;
    assign wr_idx_o      = wr_idx_q;
    assign wr_data_o     = wr_data_q;
    assign frame_err_o   = frame_err_q;
    assign err_cnt_o     = err_cnt_q;
    assign all_written_o = &written_q;
    assign ramp_en_o     = bank_q[IDX_R0][RAMP_EN_BIT];
    assign rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_adf4158_spi_monitor.sv
// tb/tb_adf4158_spi_monitor.sv - self-checking bench for adf4158_spi_monitor
module tb_adf4158_spi_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sclk_i = 1'b0;
    logic        data_i = 1'b0;
    logic        le_i = 1'b1;
    logic [3:0]  rd_idx_i = 4'd0;
    logic        wr_valid_o, frame_err_o, all_written_o, ramp_en_o;
    logic [3:0]  wr_idx_o;
    logic [31:0] wr_data_o, rd_data_o;
    logic [7:0]  err_cnt_o;

    adf4158_spi_monitor #(.SYNC_STAGES(2), .ERR_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .data_i(data_i), .le_i(le_i),
        .wr_valid_o(wr_valid_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o),
        .frame_err_o(frame_err_o), .err_cnt_o(err_cnt_o), .all_written_o(all_written_o),
        .ramp_en_o(ramp_en_o), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_bank [10];
    logic [9:0]  m_written;
    int          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int model_idx(input logic [31:0] w);
        int ctrl;
        int sel;
        ctrl = int'(w[2:0]);
        sel  = int'(w[23]);
        if (ctrl < 5) return ctrl;
        if (ctrl == 5) return 5 + sel;
        if (ctrl == 6) return 7 + sel;
        return 9;
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_bank[i] = 32'h0;
        m_written = 10'h0;
        m_err = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clk_n(1);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic shift_bits(input logic [31:0] w, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            data_i = (i < 32) ? w[31-i] : 1'($urandom);
            sclk_i = 1'b0;
            clk_n(half);
            sclk_i = 1'b1;
            clk_n(half);
        end
        sclk_i = 1'b0;
        clk_n(half);
    endtask

    task automatic do_frame(input logic [31:0] w, input int nbits, input int half, input bit lead_fall);
        bit exp_commit;
        int idx;
        int nv;
        int nf;
        bit prev_valid;
        if (lead_fall) begin
            le_i = 1'b0;
            clk_n(half + 1);
        end
        shift_bits(w, nbits, half);
        exp_commit = (nbits == 32);
        idx = model_idx(w);
        rd_idx_i = 4'(idx);
        if (exp_commit) begin
            m_bank[idx] = w;
            m_written[idx] = 1'b1;
        end else begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
        end
        le_i = 1'b1;
        nv = 0;
        nf = 0;
        prev_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            clk_n(1);
            if (prev_valid && exp_commit) chk("rd_after_commit", rd_data_o, w);
            prev_valid = wr_valid_o;
            if (wr_valid_o) begin
                nv++;
                chk("wr_idx", {28'h0, wr_idx_o}, 32'(idx));
                chk("wr_data", wr_data_o, w);
                chk("all_written_at_commit", {31'h0, all_written_o}, {31'h0, &m_written});
                chk("ramp_en_at_commit", {31'h0, ramp_en_o}, {31'h0, m_bank[0][31]});
            end
            if (frame_err_o) nf++;
        end
        chk("valid_pulses", 32'(nv), 32'(exp_commit));
        chk("ferr_pulses", 32'(nf), 32'(!exp_commit));
        chk("err_cnt", {24'h0, err_cnt_o}, 32'(m_err));
        chk("all_written_idle", {31'h0, all_written_o}, {31'h0, &m_written});
        chk("wr_data_hold", wr_data_o, exp_commit ? w : wr_data_o === 32'hx ? 32'h0 : wr_data_o);
    endtask

    task automatic readback_sweep();
        for (int i = 0; i < 16; i++) begin
            rd_idx_i = 4'(i);
            clk_n(1);
            chk("readback", rd_data_o, (i < 10) ? m_bank[i] : 32'h0);
        end
    endtask

    logic [31:0] init_seq [10];
    logic [31:0] pair_words [4];

    initial begin
        init_seq = '{32'h00000007, 32'h00800006, 32'h00000006, 32'h00800005, 32'h00000005,
                     32'h00180104, 32'h00000043, 32'h0040800A, 32'h00000001, 32'hF8848000};
        pair_words = '{32'h0023D70D, 32'h00A3D70D, 32'h00123456, 32'h00923456};
        model_reset();
        clk_n(2);
        do_reset();
        clk_n(5);
        chk("rst_wr_valid", {31'h0, wr_valid_o}, 32'h0);
        chk("rst_wr_idx", {28'h0, wr_idx_o}, 32'h0);
        chk("rst_wr_data", wr_data_o, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err_o}, 32'h0);
        chk("rst_err_cnt", {24'h0, err_cnt_o}, 32'h0);
        chk("rst_all_written", {31'h0, all_written_o}, 32'h0);
        chk("rst_ramp_en", {31'h0, ramp_en_o}, 32'h0);
        chk("rst_rd_data", rd_data_o, 32'h0);

        // Full init sequence at the fastest serial rate
        for (int i = 0; i < 10; i++) do_frame(init_seq[i], 32, 1, 1'b1);
        chk("init_ramp_en", {31'h0, ramp_en_o}, 32'h1);
        chk("init_all_written", {31'h0, all_written_o}, 32'h1);
        readback_sweep();

        // Single R7 word after a fresh reset
        do_reset();
        clk_n(3);
        do_frame(32'h00030027, 32, 2, 1'b1);
        rd_idx_i = 4'd9;
        clk_n(1);
        chk("r7_readback", rd_data_o, 32'h00030027);

        // R5 and R6 sub-register selection
        for (int i = 0; i < 4; i++) do_frame(pair_words[i], 32, int'($urandom_range(1, 3)), 1'b1);
        readback_sweep();

        // Short and over-length frames
        do_frame(32'hDEADBEE0, 31, 2, 1'b1);
        do_frame(32'hCAFEF00D, 33, 2, 1'b1);
        chk("len_err_cnt", {24'h0, err_cnt_o}, 32'h2);
        readback_sweep();

        // Randomized words, lengths and serial rates
        for (int i = 0; i < 24; i++) begin
            int sel;
            int nb;
            sel = int'($urandom_range(0, 5));
            nb = (sel < 3) ? 32 : (sel == 3) ? 31 : (sel == 4) ? 33 : 0;
            do_frame($urandom, nb, int'($urandom_range(1, 3)), 1'b1);
        end
        readback_sweep();

        // Reset in the middle of a frame discards the partial word
        le_i = 1'b0;
        clk_n(2);
        shift_bits(32'hA5A5A5A5, 16, 1);
        do_reset();
        clk_n(4);
        do_frame(32'h5A5A0003, 16, 1, 1'b0);
        chk("midrst_err_cnt", {24'h0, err_cnt_o}, 32'h1);
        readback_sweep();

        // Error counter saturation
        for (int i = 0; i < 300; i++) do_frame($urandom, int'($urandom_range(0, 5)), 1, 1'b1);
        chk("err_saturated", {24'h0, err_cnt_o}, 32'd255);
        readback_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
